// File: rtl/fila_pkg.sv
// fila_pkg: shared constants and helpers for the fila_circular FIFO.
//   FILA_WIDTH_DEF / FILA_DEPTH_DEF : default word width and entry count.
//   fila_next_ptr(ptr, depth)       : +1 increment that wraps depth-1 -> 0.
//                                     Works for non-power-of-two depths.
package fila_pkg;

  localparam int FILA_WIDTH_DEF = 8;
  localparam int FILA_DEPTH_DEF = 8;

  function automatic int unsigned fila_next_ptr(input int unsigned ptr,
                                                input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fila_ptr.sv
// fila_ptr: wrap-around pointer register for the circular FIFO.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset, pointer -> 0
//   clr_i   : synchronous clear to 0, wins over adv_i
//   adv_i   : advance by one, wrapping DEPTH-1 -> 0
//   ptr_o   : current pointer value
module fila_ptr
  import fila_pkg::*;
#(
  parameter int DEPTH = FILA_DEPTH_DEF,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic [PW-1:0] ptr_o
);

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i)      ptr_d = '0;
    else if (adv_i) ptr_d = PW'(fila_next_ptr(32'(ptr_q), DEPTH));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fila_circular.sv
// fila_circular: parametrised circular-buffer FIFO.
//   clk_10KHz       : clock, all state changes on rising edge
//   reset           : asynchronous active-low reset
//   data_in         : word to enqueue
//   enqueue_in      : enqueue request
//   dequeue_in      : dequeue request
//   clear_in        : synchronous flush, priority over enqueue/dequeue
//   data_out        : last dequeued word (registered, holds otherwise)
//   data_valid_out  : one-cycle pulse when data_out was updated
//   len_out         : occupancy 0..DEPTH
//   full_out / empty_out / almost_full_out : decoded from len_out
//   overflow_out / underflow_out           : sticky error flags
module fila_circular
  import fila_pkg::*;
#(
  parameter int WIDTH       = FILA_WIDTH_DEF,
  parameter int DEPTH       = FILA_DEPTH_DEF,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input  logic                       clk_10KHz,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       enqueue_in,
  input  logic                       dequeue_in,
  input  logic                       clear_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_valid_out,
  output logic [$clog2(DEPTH+1)-1:0] len_out,
  output logic                       full_out,
  output logic                       empty_out,
  output logic                       almost_full_out,
  output logic                       overflow_out,
  output logic                       underflow_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    head, tail;
  logic [LW-1:0]    len_q;
  logic [WIDTH-1:0] dout_q;
  logic             dv_q, ovf_q, udf_q;
  logic             deq_ok, enq_ok;

  // A full FIFO still accepts a write when a read frees the slot this cycle.
  assign deq_ok = dequeue_in && (len_q != '0);
  assign enq_ok = enqueue_in && ((len_q != LW'(DEPTH)) || deq_ok);

  fila_ptr #(.DEPTH(DEPTH), .PW(PW)) u_head (
    .clk_i (clk_10KHz),
    .rst_ni(reset),
    .clr_i (clear_in),
    .adv_i (deq_ok),
    .ptr_o (head)
  );

  fila_ptr #(.DEPTH(DEPTH), .PW(PW)) u_tail (
    .clk_i (clk_10KHz),
    .rst_ni(reset),
    .clr_i (clear_in),
    .adv_i (enq_ok),
    .ptr_o (tail)
  );

  // Storage is not reset; contents behind head/tail are meaningless anyway.
  always_ff @(posedge clk_10KHz) begin
    if (!clear_in && enq_ok) mem_q[tail] <= data_in;
  end

  always_ff @(posedge clk_10KHz or negedge reset) begin
    if (!reset) begin
      len_q  <= '0;
      dout_q <= '0;
      dv_q   <= 1'b0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else if (clear_in) begin
      len_q <= '0;
      dv_q  <= 1'b0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      dv_q <= deq_ok;
      if (deq_ok) dout_q <= mem_q[head];
      case ({enq_ok, deq_ok})
        2'b10:   len_q <= len_q + LW'(1);
        2'b01:   len_q <= len_q - LW'(1);
        default: len_q <= len_q;
      endcase
      if (enqueue_in && !enq_ok) ovf_q <= 1'b1;
      if (dequeue_in && !deq_ok) udf_q <= 1'b1;
    end
  end

  assign data_out        = dout_q;
  assign data_valid_out  = dv_q;
  assign len_out         = len_q;
  assign full_out        = (len_q == LW'(DEPTH));
  assign empty_out       = (len_q == '0);
  assign almost_full_out = (len_q >= LW'(AFULL_LEVEL));
  assign overflow_out    = ovf_q;
  assign underflow_out   = udf_q;

endmodule

// File: tb/tb_fila_circular.sv
module tb_fila_circular;

  logic       clk_10KHz = 1'b0;
  logic       reset;
  always #5 clk_10KHz = ~clk_10KHz;

  // instance A: WIDTH=8, DEPTH=8, AFULL_LEVEL=7
  logic [7:0] din_a, dout_a;
  logic       enq_a, deq_a, clr_a, dv_a, full_a, empty_a, af_a, ovf_a, udf_a;
  logic [3:0] len_a;

  // instance B: WIDTH=8, DEPTH=5, AFULL_LEVEL=4
  logic [7:0] din_b, dout_b;
  logic       enq_b, deq_b, clr_b, dv_b, full_b, empty_b, af_b, ovf_b, udf_b;
  logic [2:0] len_b;

  fila_circular #(.WIDTH(8), .DEPTH(8)) dut_a (
    .clk_10KHz(clk_10KHz), .reset(reset), .data_in(din_a),
    .enqueue_in(enq_a), .dequeue_in(deq_a), .clear_in(clr_a),
    .data_out(dout_a), .data_valid_out(dv_a), .len_out(len_a),
    .full_out(full_a), .empty_out(empty_a), .almost_full_out(af_a),
    .overflow_out(ovf_a), .underflow_out(udf_a)
  );

  fila_circular #(.WIDTH(8), .DEPTH(5), .AFULL_LEVEL(4)) dut_b (
    .clk_10KHz(clk_10KHz), .reset(reset), .data_in(din_b),
    .enqueue_in(enq_b), .dequeue_in(deq_b), .clear_in(clr_b),
    .data_out(dout_b), .data_valid_out(dv_b), .len_out(len_b),
    .full_out(full_b), .empty_out(empty_b), .almost_full_out(af_b),
    .overflow_out(ovf_b), .underflow_out(udf_b)
  );

  int total  = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_10KHz);
    #1;
  endtask

  task automatic idle_a();
    enq_a = 1'b0; deq_a = 1'b0; clr_a = 1'b0;
  endtask

  task automatic fill_a();
    for (int i = 1; i <= 8; i++) begin
      din_a = 8'(i * 8'h11); enq_a = 1'b1; deq_a = 1'b0;
      tick();
    end
    idle_a();
  endtask

  initial begin
    reset = 1'b0;
    din_a = '0; enq_a = 0; deq_a = 0; clr_a = 0;
    din_b = '0; enq_b = 0; deq_b = 0; clr_b = 0;
    #2;
    chk("rst_len", 32'(len_a), 0);
    chk("rst_empty", 32'(empty_a), 1);
    chk("rst_full", 32'(full_a), 0);
    chk("rst_afull", 32'(af_a), 0);
    chk("rst_dout", 32'(dout_a), 0);
    chk("rst_dv", 32'(dv_a), 0);
    chk("rst_ovf", 32'(ovf_a), 0);
    chk("rst_udf", 32'(udf_a), 0);
    #1 reset = 1'b1;

    // fill and drain
    fill_a();
    chk("fill_len", 32'(len_a), 8);
    chk("fill_full", 32'(full_a), 1);
    chk("fill_afull", 32'(af_a), 1);
    for (int i = 1; i <= 8; i++) begin
      deq_a = 1'b1;
      tick();
      chk("drain_dout", 32'(dout_a), 32'(8'(i * 8'h11)));
      chk("drain_dv", 32'(dv_a), 1);
    end
    idle_a();
    chk("drain_empty", 32'(empty_a), 1);
    tick();
    chk("idle_dv", 32'(dv_a), 0);
    chk("idle_dout_hold", 32'(dout_a), 32'h88);

    // full with simultaneous enqueue/dequeue
    fill_a();
    din_a = 8'hAA; enq_a = 1'b1; deq_a = 1'b1;
    tick();
    chk("fsim_dout", 32'(dout_a), 32'h11);
    chk("fsim_len", 32'(len_a), 8);
    chk("fsim_ovf", 32'(ovf_a), 0);
    enq_a = 1'b0;
    for (int i = 2; i <= 9; i++) begin
      tick();
      chk("fsim_drain", 32'(dout_a), (i == 9) ? 32'hAA : 32'(8'(i * 8'h11)));
    end
    idle_a();
    chk("fsim_empty", 32'(empty_a), 1);

    // overflow, then clear
    fill_a();
    din_a = 8'h99; enq_a = 1'b1;
    tick();
    chk("ovf_flag", 32'(ovf_a), 1);
    chk("ovf_len", 32'(len_a), 8);
    enq_a = 1'b0; deq_a = 1'b1;
    tick();
    chk("ovf_deq", 32'(dout_a), 32'h11);
    chk("ovf_sticky", 32'(ovf_a), 1);
    deq_a = 1'b0; clr_a = 1'b1; enq_a = 1'b1;
    tick();
    chk("clr_ovf", 32'(ovf_a), 0);
    chk("clr_len", 32'(len_a), 0);
    chk("clr_empty", 32'(empty_a), 1);
    chk("clr_dv", 32'(dv_a), 0);
    chk("clr_dout_hold", 32'(dout_a), 32'h11);
    idle_a();

    // empty with simultaneous enqueue/dequeue -> underflow, no bypass
    din_a = 8'h5C; enq_a = 1'b1; deq_a = 1'b1;
    tick();
    chk("esim_udf", 32'(udf_a), 1);
    chk("esim_len", 32'(len_a), 1);
    chk("esim_dv", 32'(dv_a), 0);
    chk("esim_dout", 32'(dout_a), 32'h11);
    enq_a = 1'b0;
    tick();
    chk("esim_deq", 32'(dout_a), 32'h5C);
    chk("esim_deq_dv", 32'(dv_a), 1);
    chk("esim_udf_sticky", 32'(udf_a), 1);
    idle_a();
    tick();

    // async reset mid-stream
    for (int i = 0; i < 3; i++) begin
      din_a = 8'(8'hC0 + i); enq_a = 1'b1;
      tick();
    end
    idle_a();
    chk("ar_len_pre", 32'(len_a), 3);
    #2 reset = 1'b0;
    #1;
    chk("ar_len", 32'(len_a), 0);
    chk("ar_empty", 32'(empty_a), 1);
    chk("ar_dout", 32'(dout_a), 0);
    chk("ar_udf", 32'(udf_a), 0);
    tick();
    #3 reset = 1'b1;
    din_a = 8'h42; enq_a = 1'b1;
    tick();
    idle_a();
    chk("ar_post_len", 32'(len_b === 3'd0 ? len_a : 4'hF), 1);

    // DEPTH=5 wrap-around
    din_b = 8'h10; enq_b = 1'b1; tick();
    chk("b_len1", 32'(len_b), 1);
    chk("b_af1", 32'(af_b), 0);
    din_b = 8'h11; tick();
    chk("b_len2", 32'(len_b), 2);
    deq_b = 1'b1;
    for (int k = 0; k < 12; k++) begin
      din_b = 8'(8'h12 + k);
      tick();
      chk("b_wrap_dout", 32'(dout_b), 32'(8'(8'h10 + k)));
      chk("b_wrap_len", 32'(len_b), 2);
    end
    deq_b = 1'b0;
    din_b = 8'h30; tick();
    chk("b_len3_af", 32'(af_b), 0);
    din_b = 8'h31; tick();
    chk("b_len4_af", 32'(af_b), 1);
    din_b = 8'h32; tick();
    chk("b_len5_af", 32'(af_b), 1);
    chk("b_full", 32'(full_b), 1);
    enq_b = 1'b0; deq_b = 1'b1; tick();
    chk("b_deq_1c", 32'(dout_b), 32'h1C);
    chk("b_len4b_af", 32'(af_b), 1);
    tick();
    chk("b_deq_1d", 32'(dout_b), 32'h1D);
    chk("b_len3b_af", 32'(af_b), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("b_tail_dout", 32'(dout_b), 32'(8'(8'h30 + k)));
    end
    deq_b = 1'b0;
    chk("b_empty", 32'(empty_b), 1);
    chk("b_ovf", 32'(ovf_b), 0);
    chk("b_udf", 32'(udf_b), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fila_circular.md
Name: fila_circular

Overview:
- Parametrised circular-buffer FIFO; next generation of the 8x8 shift-register queue.
- Configurable width, depth and almost-full threshold.
- Single-cycle dequeue, simultaneous enqueue/dequeue, full/empty/almost-full flags, sticky overflow/underflow errors, synchronous flush.
- Sits between the input capture logic and the display/consumer logic in the 10 kHz clock domain.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 8, number of entries (>=2; need not be a power of two).
- AFULL_LEVEL, DEPTH-1, occupancy at or above which almost_full_out is asserted (1..DEPTH).

Ports:
- clk_10KHz  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- data_in  input  WIDTH  word to enqueue.
- enqueue_in  input  1  enqueue request, sampled each rising edge.
- dequeue_in  input  1  dequeue request, sampled each rising edge.
- clear_in  input  1  synchronous flush; has priority over enqueue/dequeue.
- data_out  output  WIDTH  last dequeued word, registered.
- data_valid_out  output  1  one-cycle pulse: data_out updated this cycle.
- len_out  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- full_out  output  1  len_out == DEPTH.
- empty_out  output  1  len_out == 0.
- almost_full_out  output  1  len_out >= AFULL_LEVEL.
- overflow_out  output  1  sticky: enqueue attempted while full without a same-cycle dequeue.
- underflow_out  output  1  sticky: dequeue attempted while empty.

Behaviour:
- Reset (reset=0, asynchronous):
  - head, tail and len cleared to 0.
  - data_out=0, data_valid_out=0, overflow_out=0, underflow_out=0.
  - empty_out=1, full_out=0; almost_full_out=0.
  - Memory contents are don't-care.
- Reset release is synchronous in effect: the first active edge after deassertion is a normal cycle.
- Storage: DEPTH x WIDTH array, head (read) and tail (write) pointers.
  - Pointers advance by +1 and wrap from DEPTH-1 to 0; supports non-power-of-two DEPTH.
- Per rising edge, priority order:
  1. clear_in=1:
     - head=tail=len=0; overflow_out and underflow_out cleared; data_valid_out=0.
     - data_out holds its value.
     - enqueue_in and dequeue_in are ignored; no error flags set.
  2. Otherwise, compute deq_ok = dequeue_in && len>0.
  3. Compute enq_ok = enqueue_in && (len<DEPTH || deq_ok).
- Dequeue (deq_ok):
  - data_out <= mem[head]; data_valid_out=1 in the following cycle only; head advances.
  - Latency is 1 cycle from request edge to data_out valid. There is no extra shift cycle.
- Enqueue (enq_ok): mem[tail] <= data_in; tail advances.
- Occupancy:
  - len += 1 if enq_ok && !deq_ok.
  - len -= 1 if deq_ok && !enq_ok.
  - Otherwise len is unchanged.
- Full with both requests: both accepted; old head word is read and the new word written; len stays DEPTH; no overflow.
- Empty with both requests: enqueue accepted, dequeue rejected; underflow_out set; len becomes 1; data_out unchanged. No bypass path.
- Full with enqueue only: word dropped, overflow_out set, state unchanged.
- Empty with dequeue only: underflow_out set, data_out unchanged, data_valid_out=0.
- Sticky flags hold until clear_in or reset.
- Flags full_out, empty_out and almost_full_out decode combinationally from the registered len. They are valid in the same cycle len_out updates.
- Width rules:
  - len_out is unsigned and never exceeds DEPTH or wraps below 0.
  - Pointer width is $clog2(DEPTH).
  - All comparisons are unsigned.
- Reset asserted mid-operation: contents are discarded immediately and all outputs take their reset values asynchronously.

Decomposition:
- Package fila_pkg:
  - Default constants FILA_WIDTH_DEF=8 and FILA_DEPTH_DEF=8.
  - Function fila_next_ptr(ptr, depth) implementing wrap-around increment.
- One sub-module, fila_ptr: a parametrised wrap-around pointer register (DEPTH) with async active-low reset, advance and clear inputs. It is instantiated twice, for head and tail.
- Storage array, occupancy counter and flag logic live in fila_circular.

Test Plan:
- Fill and drain (WIDTH=8, DEPTH=8): enqueue 0x11..0x88 -> full_out=1, len_out=8; then 8 dequeues -> data_out 0x11..0x88 in order, each with data_valid_out, then empty_out=1.
- Overflow: full, enqueue 0x99 only -> overflow_out=1, len_out=8; next dequeue returns 0x11, not 0x99. Then clear_in -> overflow_out=0, len_out=0.
- Full simultaneous: full, enqueue 0xAA and dequeue in the same cycle -> data_out=0x11, len_out=8, overflow_out=0; after draining, 0xAA appears last.
- Empty simultaneous and underflow: empty, enqueue 0x5C with dequeue -> underflow_out=1, len_out=1, data_valid_out=0; next dequeue -> data_out=0x5C.
- Wrap-around with DEPTH=5, AFULL_LEVEL=4:
  - Interleave 12 enqueue/dequeue pairs -> FIFO order preserved across pointer wrap.
  - almost_full_out=1 exactly when len_out>=4.
- Async reset mid-stream: len_out=3, drive reset=0 between clock edges -> outputs go to reset values before the next edge; first post-release enqueue gives len_out=1.
